// File: rtl/random_sampler_pkg.sv
// Shared types and helpers for the random sampler.
//   state_t   : sampler FSM states (IDLE, RETRY)
//   is_reject : decides whether a sampled value must be discarded
package random_sampler_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    RETRY = 1'b1
  } state_t;

  // Values are passed zero-extended to 32 bits so one helper serves any bus width.
  function automatic logic is_reject(
    input logic [31:0] number,
    input logic [31:0] last,
    input logic        have_last,
    input int unsigned modulus,
    input logic        no_repeat
  );
    logic out_of_range;
    logic repeat_hit;
    out_of_range = (number >= modulus);
    repeat_hit   = no_repeat && (modulus > 1) && have_last && (number == last);
    return out_of_range || repeat_hit;
  endfunction

endpackage

// File: rtl/random_sampler_sync_fifo.sv
// Single-clock FIFO with separately tracked occupancy.
//   clk, rst        : clock, async active-high reset
//   push, data_in   : write request and data (ignored when full)
//   pop             : read request (ignored when empty)
//   data_out        : head entry, forced to 0 when empty
//   full, empty     : occupancy flags
//   level           : entry count, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/random_sampler.sv
// Samples a free-running random source on request, resampling on later cycles
// when the value is out of range or repeats the last accepted value, and
// buffers accepted values for a valid/ready consumer.
//   clk, rst   : clock, async active-high reset
//   number     : current random source value
//   req        : sample request
//   out_data   : FIFO head (0 when empty)
//   out_valid  : FIFO non-empty
//   out_ready  : downstream accepts out_data
//   busy       : waiting for an acceptable value
//   drop       : one-cycle pulse, a request was discarded
//   level      : FIFO occupancy
module random_sampler
  import random_sampler_pkg::*;
#(
  parameter int unsigned MODULUS   = 10,
  parameter int unsigned NBITS     = (MODULUS > 1) ? $clog2(MODULUS) : 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NO_REPEAT = 1,
  parameter int unsigned LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] number,
  input  logic             req,
  output logic [NBITS-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop,
  output logic [LW-1:0]    level
);

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] last;
  logic             have_last;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             reject;
  logic             drop_next;

  assign reject = is_reject(32'(number), 32'(last), have_last, MODULUS, (NO_REPEAT != 0));

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state == RETRY);

  sync_fifo #(
    .WIDTH (NBITS),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .data_in  (number),
    .pop      (pop),
    .data_out (out_data),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // State, drop pulse and last-accepted tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drop      <= 1'b0;
      last      <= '0;
      have_last <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (push) begin
        last      <= number;
        have_last <= 1'b1;
      end
    end
  end

  // Next-state and push/drop decode; full is checked before this cycle's pop.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    drop_next  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (full)        drop_next  = 1'b1;
          else if (reject) state_next = RETRY;
          else             push       = 1'b1;
        end
      end
      RETRY: begin
        if (req) drop_next = 1'b1;
        if (!reject && !full) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_random_sampler.sv
// Scoreboard bench for random_sampler (MODULUS=10, DEPTH=4, NO_REPEAT=1).
module tb_random_sampler;

  localparam int unsigned MODULUS = 10;
  localparam int unsigned NBITS   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LW      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             out_ready = 1'b0;
  logic [NBITS-1:0] number = '0;
  logic [NBITS-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             drop;
  logic [LW-1:0]    level;

  int tests = 0;
  int fails = 0;
  logic [NBITS-1:0] exp_q [$];
  logic [NBITS-1:0] fill_vals [4] = '{4'd1, 4'd2, 4'd4, 4'd5};

  random_sampler #(
    .MODULUS   (MODULUS),
    .NBITS     (NBITS),
    .DEPTH     (DEPTH),
    .NO_REPEAT (1),
    .LW        (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .number    (number),
    .req       (req),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop      (drop),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake beat must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'(out_valid), 32'd0);
        end else begin
          chk("pop_data", 32'(out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_drop",  32'(drop),      32'd0);
    chk("rst_level", 32'(level),     32'd0);
    rst = 1'b0;
    step();

    // First accepted request
    number = 4'd7; req = 1'b1; exp_q.push_back(4'd7);
    step();
    req = 1'b0;
    chk("acc_valid", 32'(out_valid), 32'd1);
    chk("acc_data",  32'(out_data),  32'd7);
    chk("acc_level", 32'(level),     32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("drain1_level", 32'(level), 32'd0);

    // Repeat rejected, next value taken on retry
    number = 4'd7; req = 1'b1;
    step();
    req = 1'b0; number = 4'd8; exp_q.push_back(4'd8);
    chk("rep_busy", 32'(busy), 32'd1);
    chk("rep_level", 32'(level), 32'd0);
    step();
    chk("rep_busy_clr", 32'(busy), 32'd0);
    chk("rep_level2", 32'(level), 32'd1);
    chk("rep_data", 32'(out_data), 32'd8);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Out-of-range rejected
    number = 4'd12; req = 1'b1;
    step();
    req = 1'b0; number = 4'd3; exp_q.push_back(4'd3);
    chk("oor_busy", 32'(busy), 32'd1);
    step();
    chk("oor_busy_clr", 32'(busy), 32'd0);
    chk("oor_level", 32'(level), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Fill to DEPTH, then drop on full
    foreach (fill_vals[i]) begin
      number = fill_vals[i]; req = 1'b1; exp_q.push_back(fill_vals[i]);
      step();
    end
    req = 1'b0;
    chk("full_level", 32'(level), 32'd4);
    number = 4'd6; req = 1'b1;
    step();
    req = 1'b0;
    chk("full_drop", 32'(drop), 32'd1);
    chk("full_level_hold", 32'(level), 32'd4);
    chk("full_busy", 32'(busy), 32'd0);
    step();
    chk("drop_clear", 32'(drop), 32'd0);
    number = 4'd6; req = 1'b1; out_ready = 1'b1;
    step();
    req = 1'b0; out_ready = 1'b0;
    chk("full_pop_drop", 32'(drop), 32'd1);
    chk("full_pop_level", 32'(level), 32'd3);

    // Backpressure: head stable while not ready
    for (int i = 0; i < 3; i++) begin
      number = 4'(i + 9);
      chk("bp_stable", 32'(out_data), 32'd2);
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_data",  32'(out_data),  32'd0);
    chk("empty_level", 32'(level),     32'd0);

    // Reset during RETRY with two entries
    number = 4'd6; req = 1'b1; exp_q.push_back(4'd6);
    step();
    number = 4'd7; exp_q.push_back(4'd7);
    step();
    step();
    req = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_level", 32'(level), 32'd2);
    step();
    chk("retry_hold", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_drop",  32'(drop),      32'd0);
    chk("mid_rst_level", 32'(level),     32'd0);
    step();
    rst = 1'b0;
    number = 4'd7; req = 1'b1; exp_q.push_back(4'd7);
    step();
    req = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  32'(out_data),  32'd7);
    chk("post_rst_busy",  32'(busy),      32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
